// File: rtl/spi_pkg.sv
// spi_pkg: types and constants shared by the SPI peripheral and the controller side.
//   spi_state_t                  - frame state of the peripheral FSM
//   SPI_LENGTH_RECIEVED_DEFAULT  - default command word length (bits)
//   SPI_LENGTH_SEND_DEFAULT      - default reply word length (bits)
//   spi_cnt_width()              - bit counter width covering both word lengths
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    TX   = 2'd2,
    DONE = 2'd3
  } spi_state_t;

  localparam int SPI_LENGTH_RECIEVED_DEFAULT = 8;
  localparam int SPI_LENGTH_SEND_DEFAULT     = 16;

  // The counter must hold the full word length so it never wraps inside a frame.
  function automatic int spi_cnt_width(input int len_a, input int len_b);
    return $clog2(((len_a > len_b) ? len_a : len_b) + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-stage synchronizer for an asynchronous pin with
// single-cycle rise/fall pulses derived from the synchronized level.
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   din   in   asynchronous pin
//   dout  out  synchronized level
//   rise  out  one-cycle pulse on a synchronized 0->1 transition
//   fall  out  one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset the whole chain and the history copy to the pin's idle level so
  // leaving reset never manufactures an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_peripheral_rx_tx.sv
// spi_peripheral_rx_tx: SPI mode-0 responder. Receives a command word, then
// returns a reply word in the same chip-select frame.
//   clk, rst           system clock, synchronous active-high reset
//   sclk, cs_n, copi   SPI pins from the controller (asynchronous)
//   cipo               reply data to the controller
//   tx_data/valid/ready  reply word handshake from user logic
//   rx_data/rx_valid   last complete command word, one-cycle valid pulse
//   busy               frame in progress
//   underrun           one-cycle pulse: frame started with no reply buffered
//
// state | meaning
// IDLE  | waiting for cs_n to fall, cipo held low
// RX    | shifting command bits in on sclk rising edges
// TX    | presenting reply bits, shifting on sclk falling edges
// DONE  | reply complete, sclk ignored until cs_n rises
module spi_peripheral_rx_tx
  import spi_pkg::*;
#(
  parameter int LENGTH_RECIEVED_P = SPI_LENGTH_RECIEVED_DEFAULT,
  parameter int LENGTH_SEND_P     = SPI_LENGTH_SEND_DEFAULT,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         cs_n,
  input  logic                         copi,
  output logic                         cipo,
  input  logic [LENGTH_SEND_P-1:0]     tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [LENGTH_RECIEVED_P-1:0] rx_data,
  output logic                         rx_valid,
  output logic                         busy,
  output logic                         underrun
);

  localparam int CNT_W = spi_cnt_width(LENGTH_RECIEVED_P, LENGTH_SEND_P);
  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(LENGTH_RECIEVED_P - 1);
  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(LENGTH_SEND_P - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic copi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .dout (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk  (clk),
    .rst  (rst),
    .din  (cs_n),
    .dout (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // copi only needs its level, matched in depth to sclk so data and clock align.
  always_ff @(posedge clk) begin
    if (rst) copi_sync_q <= '0;
    else     copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
  end
  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  spi_state_t                   state;
  logic [CNT_W-1:0]             bit_cnt;
  logic [LENGTH_RECIEVED_P-1:0] rx_shift;
  logic [LENGTH_SEND_P-1:0]     tx_shift;
  logic [LENGTH_SEND_P-1:0]     tx_buf;
  logic                         buf_full;
  logic                         rx_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      tx_buf   <= '0;
      buf_full <= 1'b0;
      rx_pend  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      cipo     <= 1'b0;
    end else begin
      rx_pend  <= 1'b0;
      rx_valid <= rx_pend;
      underrun <= 1'b0;

      if (tx_valid && !buf_full) begin
        tx_buf   <= tx_data;
        buf_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          cipo <= 1'b0;
          if (cs_fall) begin
            state   <= RX;
            bit_cnt <= '0;
            // Only clear buf_full when it was set, so a load landing in this
            // same cycle is kept for the next frame.
            if (buf_full) begin
              tx_shift <= tx_buf;
              buf_full <= 1'b0;
            end else begin
              tx_shift <= '0;
              underrun <= 1'b1;
            end
          end
        end

        RX: begin
          if (cs_rise) begin
            state <= IDLE;
            cipo  <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[LENGTH_RECIEVED_P-2:0], copi_s};
            if (bit_cnt == LAST_RX) begin
              rx_data <= {rx_shift[LENGTH_RECIEVED_P-2:0], copi_s};
              rx_pend <= 1'b1;
              bit_cnt <= '0;
              state   <= TX;
              cipo    <= tx_shift[LENGTH_SEND_P-1];
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        TX: begin
          if (cs_rise) begin
            state <= IDLE;
            cipo  <= 1'b0;
          end else if (sclk_rise) begin
            if (bit_cnt == LAST_TX) begin
              state <= DONE;
              cipo  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall && bit_cnt != '0) begin
            // bit_cnt==0 means the falling edge left over from the RX phase.
            tx_shift <= {tx_shift[LENGTH_SEND_P-2:0], 1'b0};
            cipo     <= tx_shift[LENGTH_SEND_P-2];
          end
        end

        DONE: begin
          cipo <= 1'b0;
          if (cs_rise) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign tx_ready = ~buf_full;

endmodule

// File: tb/tb_spi_peripheral_rx_tx.sv
module tb_spi_peripheral_rx_tx;

  localparam int H = 6; // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst, sclk, cs_n, copi, cipo;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, busy, underrun;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0]  exp_rx_q[$];
  bit          exp_und_q[$];
  bit          model_full;
  logic [15:0] model_buf;
  logic [7:0]  model_rx;
  logic        busy_prev = 1'b0;

  always #5 clk = ~clk;

  spi_peripheral_rx_tx #(
    .LENGTH_RECIEVED_P(8),
    .LENGTH_SEND_P    (16),
    .SYNC_STAGES      (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .copi    (copi),
    .cipo    (cipo),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .underrun(underrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_rx_q.size() == 0) check("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
        else                      check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
      end
      if (busy && !busy_prev) begin
        if (exp_und_q.size() == 0) check("frame_start_unexpected", {31'd0, busy}, 32'd0);
        else                       check("underrun", {31'd0, underrun}, {31'd0, exp_und_q.pop_front()});
      end else if (underrun) begin
        check("underrun_stray", {31'd0, underrun}, 32'd0);
      end
    end
    busy_prev = busy;
  end

  task automatic load_reply(input logic [15:0] d);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 50) begin
      clks(1);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    end else begin
      tx_data  = d;
      tx_valid = 1'b1;
      clks(1);
      tx_valid = 1'b0;
      model_full = 1'b1;
      model_buf  = d;
      check("tx_ready_after_load", {31'd0, tx_ready}, 32'd0);
    end
  endtask

  // abort_after < 0: full frame; rst_bit < 0: no reset during TX.
  task automatic frame(input logic [7:0] w, input int abort_after, input int extra,
                       input int rst_bit);
    logic [15:0] exp_reply;
    logic [15:0] got;
    int          nrx;
    got = '0;
    exp_und_q.push_back(!model_full);
    exp_reply  = model_full ? model_buf : 16'h0000;
    model_full = 1'b0;
    if (abort_after < 0) begin
      exp_rx_q.push_back(w);
      model_rx = w;
    end
    nrx = (abort_after < 0) ? 8 : abort_after;

    cs_n = 1'b0;
    clks(H);
    for (int k = 0; k < nrx; k++) begin
      copi = w[7-k];
      clks(H);
      sclk = 1'b1;
      clks(H);
      sclk = 1'b0;
    end

    if (abort_after >= 0) begin
      clks(H);
      cs_n = 1'b1;
      clks(4);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_rx_data", {24'd0, rx_data}, {24'd0, model_rx});
      clks(4);
      return;
    end

    for (int k = 0; k < 16; k++) begin
      clks(H);
      if (k == rst_bit) begin
        rst  = 1'b1;
        cs_n = 1'b1;
        sclk = 1'b0;
        clks(1);
        rst = 1'b0;
        check("rst_cipo",     {31'd0, cipo},     32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_data",  {24'd0, rx_data},  32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        model_full = 1'b0;
        model_rx   = 8'h00;
        clks(4);
        return;
      end
      got[15-k] = cipo;
      sclk = 1'b1;
      clks(H);
      sclk = 1'b0;
    end

    for (int e = 0; e < extra; e++) begin
      clks(H);
      check("done_cipo", {31'd0, cipo}, 32'd0);
      sclk = 1'b1;
      clks(H);
      sclk = 1'b0;
    end

    clks(H);
    cs_n = 1'b1;
    clks(8);
    check("reply", {16'd0, got}, {16'd0, exp_reply});
    check("tx_ready_after_frame", {31'd0, tx_ready}, {31'd0, !model_full});
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; copi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    model_full = 1'b0; model_buf = '0; model_rx = 8'h00;
    clks(3);
    check("reset_cipo",     {31'd0, cipo},     32'd0);
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_rx_data",  {24'd0, rx_data},  32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_busy",     {31'd0, busy},     32'd0);
    check("reset_underrun", {31'd0, underrun}, 32'd0);
    rst = 1'b0;
    clks(4);

    load_reply(16'hA5A5);
    frame(8'h3C, -1, 0, -1);

    frame(8'hFF, -1, 0, -1);

    frame(8'h5A, 3, 0, -1);

    for (int i = 0; i < 10; i++) begin
      w = 8'($urandom_range(0, 255));
      load_reply({w, w});
      frame(w, -1, 0, -1);
    end

    load_reply(16'hBEEF);
    frame(8'h42, -1, 4, -1);
    load_reply(16'h0F0F);
    frame(8'h99, -1, 0, -1);

    load_reply(16'h1357);
    frame(8'h66, -1, 0, 5);
    load_reply(16'h1234);
    frame(8'h81, -1, 0, -1);

    clks(10);
    check("rx_queue_drained",  exp_rx_q.size(),  32'd0);
    check("und_queue_drained", exp_und_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
